// File: rtl/nanorv32_periph_fabric.sv
// nanorv32_periph_fabric: routes the core's peripheral port to NSLV slaves by address decode.
// Latency: a slave ready on request cycle n gives periph_ready_nxt_o in cycle n, and dout/err in cycle n+1.
// Backpressure: the master holds its request until periph_ready_nxt_o; slave wait states, unmapped
//   addresses and timeouts (TIMEOUT cycles) all finish through that same handshake.
// Ports:
//   clk, rst                       clock and asynchronous active-high reset
//   periph_en/addr/bytesel/din_i   master request (a nonzero bytesel is a write)
//   periph_ready_nxt_o             the transfer completes at this clock edge
//   periph_dout_o, periph_err_o    registered result of the last completion
//   err_addr_o, err_cnt_o          address of the last error, and a saturating error count
//   bus_slv_en/addr/bytesel/din_o  one-hot slave select plus the shared request fields
//   slv_bus_dout_i, slv_bus_ready_nxt_i  per-slave read data and completion
module nanorv32_periph_fabric #(
  parameter int NSLV       = 4,
  parameter int ADDR_W     = 12,
  parameter int SLV_ADDR_W = 8,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 16,
  parameter int ERRCNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   periph_en_i,
  input  logic [ADDR_W-1:0]      periph_addr_i,
  input  logic [3:0]             periph_bytesel_i,
  input  logic [DATA_W-1:0]      periph_din_i,
  output logic                   periph_ready_nxt_o,
  output logic [DATA_W-1:0]      periph_dout_o,
  output logic                   periph_err_o,
  output logic [ADDR_W-1:0]      err_addr_o,
  output logic [ERRCNT_W-1:0]    err_cnt_o,
  output logic [NSLV-1:0]        bus_slv_en_o,
  output logic [SLV_ADDR_W-1:0]  bus_slv_addr_o,
  output logic [3:0]             bus_slv_bytesel_o,
  output logic [DATA_W-1:0]      bus_slv_din_o,
  input  logic [NSLV*DATA_W-1:0] slv_bus_dout_i,
  input  logic [NSLV-1:0]        slv_bus_ready_nxt_i
);

  localparam int IDX_W = ADDR_W - SLV_ADDR_W;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   dout_q;
  logic                err_q;
  logic [ADDR_W-1:0]   err_addr_q;
  logic [ERRCNT_W-1:0] err_cnt_q;

  logic [IDX_W-1:0]    req_idx;
  logic [IDX_W-1:0]    sel_idx;
  logic                mapped;
  logic                sel_rdy;
  logic [DATA_W-1:0]   sel_dat;
  logic [NSLV-1:0]     sel_onehot;
  logic                drive;
  logic                cpl;
  logic                cpl_err;

  assign req_idx = periph_addr_i[ADDR_W-1:SLV_ADDR_W];
  assign mapped  = int'(req_idx) < NSLV;
  // In ACTIVE the latched index steers the mux, so a changed address cannot retarget a transfer that is in flight.
  assign sel_idx = (state_q == S_ACTIVE) ? idx_q : req_idx;

  // Only the selected slave's ready and data are seen; ready from any other slave is ignored.
  always_comb begin
    sel_rdy    = 1'b0;
    sel_dat    = '0;
    sel_onehot = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_rdy       = slv_bus_ready_nxt_i[i];
        sel_dat       = slv_bus_dout_i[i*DATA_W +: DATA_W];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    drive   = 1'b0;
    cpl     = 1'b0;
    cpl_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (periph_en_i) begin
          if (mapped) begin
            drive = 1'b1;
            if (sel_rdy) begin
              cpl = 1'b1;
            end else begin
              state_d = S_ACTIVE;
              idx_d   = req_idx;
              cnt_d   = CNT_W'(1);
            end
          end else begin
            cpl     = 1'b1;
            cpl_err = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        if (!periph_en_i) begin
          // The master aborted: return to IDLE quietly, with no completion and no error.
          state_d = S_IDLE;
        end else begin
          drive = 1'b1;
          if (sel_rdy) begin
            cpl     = 1'b1;
            state_d = S_IDLE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            cpl     = 1'b1;
            cpl_err = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      dout_q     <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      if (cpl) begin
        // Writes and errors return zero; only a normal read returns slave data.
        dout_q <= (cpl_err || (periph_bytesel_i != 4'b0000)) ? '0 : sel_dat;
        err_q  <= cpl_err;
        if (cpl_err) begin
          err_addr_q <= periph_addr_i;
          if (err_cnt_q != {ERRCNT_W{1'b1}}) begin
            err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
          end
        end
      end
    end
  end

  // The strobes are gated with rst so that no slave sees a select and the master sees no ready while reset is held.
  assign periph_ready_nxt_o = cpl & ~rst;
  assign bus_slv_en_o       = (drive && !rst) ? sel_onehot : '0;
  assign bus_slv_addr_o     = periph_addr_i[SLV_ADDR_W-1:0];
  assign bus_slv_bytesel_o  = periph_bytesel_i;
  assign bus_slv_din_o      = periph_din_i;
  assign periph_dout_o      = dout_q;
  assign periph_err_o       = err_q;
  assign err_addr_o         = err_addr_q;
  assign err_cnt_o          = err_cnt_q;

endmodule
